// File: rtl/branch_pkg.sv
// Shared types for the branch prediction path: resolve-queue FSM states,
// direction constants, queue entry layout and 2-bit counter encodings.
// Pure declarations; no logic or latency.
package branch_pkg;

  // Resolve-queue control state
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brq_state_t;

  // Branch direction encodings
  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  // Canonical in-flight entry at the default tag width
  localparam int BR_PC_W = 8;
  typedef struct packed {
    logic               taken;
    logic [BR_PC_W-1:0] pc;
  } br_entry_t;

  // 2-bit saturating counter states, shared with the predictor
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr2_t;

  // The predictor's direction is the counter MSB
  function automatic logic ctr2_predict(input ctr2_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_fifo.sv
// Circular buffer of DEPTH entries with push/pop/clear and an entry count.
// Head data is combinational from storage; pointer/count update on the edge.
// No internal backpressure: the owner must not push when full or pop when empty.
module branch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Entry storage: written at the tail on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_tail] <= i_din;
    end
  end

  // Pointers and count; clear discards everything by collapsing head onto tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predictions; checks each against its resolved outcome.
// Training/flush/error outputs are registered: one cycle after the resolve edge.
// pred_ready drops when full or during the one-cycle FLUSH; resolves are never stalled.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pred_valid,
  input  logic                   pred_taken,
  input  logic [PC_W-1:0]        pred_pc,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic                   upd_taken,
  output logic [PC_W-1:0]        upd_pc,
  output logic                   flush,
  output logic                   redirect_taken,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       mispredict_cnt,
  output logic                   res_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  brq_state_t     r_state;
  brq_state_t     w_state_nxt;
  logic [PC_W:0]  w_head;
  logic [CW-1:0]  w_count;
  logic           w_res_ok;
  logic           w_mispredict;
  logic           w_push;
  logic           w_pop;

  branch_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({pred_taken, pred_pc}),
    .i_pop   (w_pop),
    .i_clear (w_mispredict),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // A resolve only acts when there is an entry to check; the head carries {taken, pc}
  assign w_res_ok     = res_valid && (w_count != '0);
  assign w_mispredict = w_res_ok && (res_taken != w_head[PC_W]);
  assign w_pop        = w_res_ok && !w_mispredict;

  // Readiness uses the current count, so a simultaneous pop cannot free a full slot
  assign pred_ready = (r_state == ST_RUN) && (w_count < FULL);
  // A push alongside a mispredict is wrong-path and is dropped
  assign w_push     = pred_valid && pred_ready && !w_mispredict;
  assign occupancy  = w_count;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: a mispredict holds off new predictions for exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_mispredict) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Training, redirect and error pulses, each one cycle wide after the resolve edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid      <= 1'b0;
      upd_taken      <= NOT_TAKEN;
      upd_pc         <= '0;
      flush          <= 1'b0;
      redirect_taken <= NOT_TAKEN;
      res_err        <= 1'b0;
    end else begin
      upd_valid      <= w_res_ok;
      upd_taken      <= w_res_ok ? res_taken : NOT_TAKEN;
      upd_pc         <= w_res_ok ? w_head[PC_W-1:0] : '0;
      flush          <= w_mispredict;
      redirect_taken <= w_mispredict ? res_taken : NOT_TAKEN;
      res_err        <= res_valid && (w_count == '0);
    end
  end

  // Mispredict statistics, saturating at all-ones; moves on the same edge flush rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (w_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench: a default build plus a CNT_W=4 build share all stimulus,
// the narrow build exposing mispredict counter saturation.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, res_valid, res_taken;
  logic [7:0] pred_pc;

  logic        pred_ready, upd_valid, upd_taken, flush, redirect_taken, res_err;
  logic [7:0]  upd_pc;
  logic [2:0]  occupancy;
  logic [15:0] mispredict_cnt;

  logic        b_pred_ready, b_upd_valid, b_upd_taken, b_flush, b_redirect_taken, b_res_err;
  logic [7:0]  b_upd_pc;
  logic [2:0]  b_occupancy;
  logic [3:0]  b_mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .flush(flush), .redirect_taken(redirect_taken), .occupancy(occupancy),
    .mispredict_cnt(mispredict_cnt), .res_err(res_err)
  );

  branch_resolve_queue #(.DEPTH(4), .PC_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_ready(b_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(b_upd_valid), .upd_taken(b_upd_taken), .upd_pc(b_upd_pc),
    .flush(b_flush), .redirect_taken(b_redirect_taken), .occupancy(b_occupancy),
    .mispredict_cnt(b_mispredict_cnt), .res_err(b_res_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [7:0] pc,
                       input logic rv, input logic rt);
    pred_valid = pv;
    pred_taken = pt;
    pred_pc    = pc;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dir4;
    logic [2:0] dir3;
    rst_n = 1'b0;
    drive(0, 0, 8'd0, 0, 0);
    #1;
    // Reset values
    chk("rst_pred_ready", 32'(pred_ready), 1);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_mcnt", 32'(mispredict_cnt), 0);
    step();
    step();
    rst_n = 1'b1;

    // Fill: T,N,T,T with pc 1..4
    dir4 = 4'b1101;   // bit i = direction of entry i
    for (int i = 0; i < 4; i++) begin
      drive(1, dir4[i], 8'(i + 1), 0, 0);
      step();
      if (i == 0) chk("push1_occ", 32'(occupancy), 1);
    end
    chk("full_occ", 32'(occupancy), 4);
    chk("full_ready", 32'(pred_ready), 0);
    drive(1, 1, 8'd5, 0, 0);
    step();
    chk("push5_ignored_occ", 32'(occupancy), 4);

    // Resolve all four correctly
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'd0, 1, dir4[i]);
      step();
      chk("res_upd_valid", 32'(upd_valid), 1);
      chk("res_upd_pc", 32'(upd_pc), i + 1);
      chk("res_upd_taken", 32'(upd_taken), 32'(dir4[i]));
      chk("res_no_flush", 32'(flush), 0);
    end
    drive(0, 0, 8'd0, 0, 0);
    step();
    chk("drain_upd_valid", 32'(upd_valid), 0);
    chk("drain_occ", 32'(occupancy), 0);

    // Push T,T,N then mispredict the oldest
    dir3 = 3'b011;
    for (int i = 0; i < 3; i++) begin
      drive(1, dir3[i], 8'(i + 1), 0, 0);
      step();
    end
    chk("push3_occ", 32'(occupancy), 3);
    drive(0, 0, 8'd0, 1, 0);
    step();
    chk("mp_flush", 32'(flush), 1);
    chk("mp_redirect", 32'(redirect_taken), 0);
    chk("mp_upd_valid", 32'(upd_valid), 1);
    chk("mp_upd_pc", 32'(upd_pc), 1);
    chk("mp_mcnt", 32'(mispredict_cnt), 1);
    chk("mp_occ", 32'(occupancy), 0);
    chk("mp_ready_low", 32'(pred_ready), 0);
    drive(0, 0, 8'd0, 0, 0);
    step();
    chk("mp_flush_end", 32'(flush), 0);
    chk("mp_ready_back", 32'(pred_ready), 1);

    // Resolve on empty queue
    drive(0, 0, 8'd0, 1, 1);
    step();
    chk("empty_res_err", 32'(res_err), 1);
    chk("empty_no_upd", 32'(upd_valid), 0);
    chk("empty_mcnt", 32'(mispredict_cnt), 1);
    chk("empty_occ", 32'(occupancy), 0);
    drive(0, 0, 8'd0, 0, 0);
    step();
    chk("empty_err_pulse", 32'(res_err), 0);

    // Full queue with simultaneous push and correct resolve
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(10 + i), 0, 0);
      step();
    end
    drive(1, 1, 8'd14, 1, 1);
    step();
    chk("fullpr_upd_pc", 32'(upd_pc), 10);
    chk("fullpr_occ", 32'(occupancy), 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'd0, 1, 1);
      step();
      chk("fullpr_drain_pc", 32'(upd_pc), 11 + i);
    end
    chk("fullpr_empty", 32'(occupancy), 0);

    // Non-full push with correct resolve, then push with mispredict
    drive(1, 1, 8'd20, 0, 0);
    step();
    drive(1, 0, 8'd21, 1, 1);
    step();
    chk("pr_upd_pc", 32'(upd_pc), 20);
    chk("pr_occ", 32'(occupancy), 1);
    drive(1, 1, 8'd22, 1, 1);
    step();
    chk("pmp_flush", 32'(flush), 1);
    chk("pmp_redirect", 32'(redirect_taken), 1);
    chk("pmp_upd_pc", 32'(upd_pc), 21);
    chk("pmp_occ", 32'(occupancy), 0);
    chk("pmp_mcnt", 32'(mispredict_cnt), 2);
    // During FLUSH: push refused and resolve flagged as error
    drive(1, 1, 8'd23, 1, 1);
    step();
    chk("flush_res_err", 32'(res_err), 1);
    chk("flush_no_upd", 32'(upd_valid), 0);
    chk("flush_push_refused", 32'(occupancy), 0);
    chk("flush_ready_back", 32'(pred_ready), 1);
    drive(0, 0, 8'd0, 0, 0);
    step();

    // Fifteen more mispredicts: 17 total, narrow counter holds at 15
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 8'(40 + i), 0, 0);
      step();
      drive(0, 0, 8'd0, 1, 0);
      step();
      drive(0, 0, 8'd0, 0, 0);
      step();
      if (i == 12) begin
        chk("sat_main_15", 32'(mispredict_cnt), 15);
        chk("sat_narrow_15", 32'(b_mispredict_cnt), 15);
      end
    end
    chk("sat_main_17", 32'(mispredict_cnt), 17);
    chk("sat_narrow_hold", 32'(b_mispredict_cnt), 15);

    // Reset asserted mid-queue while a training pulse is live
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'(30 + i), 0, 0);
      step();
    end
    drive(0, 0, 8'd0, 1, 1);
    step();
    chk("pre_rst_upd_valid", 32'(upd_valid), 1);
    chk("pre_rst_occ", 32'(occupancy), 2);
    drive(0, 0, 8'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_upd_valid", 32'(upd_valid), 0);
    chk("arst_upd_pc", 32'(upd_pc), 0);
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_ready", 32'(pred_ready), 1);
    chk("arst_mcnt", 32'(mispredict_cnt), 0);
    chk("arst_narrow_mcnt", 32'(b_mispredict_cnt), 0);
    rst_n = 1'b1;
    drive(0, 0, 8'd0, 1, 1);
    step();
    chk("post_rst_res_err", 32'(res_err), 1);
    chk("post_rst_no_upd", 32'(upd_valid), 0);
    drive(0, 0, 8'd0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
